instruction_decode: RTL and testbench
=====================================

# instruction_decode

Second pipeline stage of kakacpu. It sits downstream of instruction_fetch and consumes its valid/data/stall stream, so it is the reader at the other end of the fetch output interface. It decodes RV32I words into register indices, a sign-extended immediate and an instruction class, and presents them to execute through a registered valid/stall handshake. A two-entry skid buffer keeps `stall_output` registered, so no combinational path runs from execute back to fetch.

## Interface
- `XLEN`, 32: data/address width; only 32 is supported.
- `clk` input 1: system clock (CLOCK_50 at top).
- `rst` input 1: asynchronous, active-low reset.
- `valid_input` input 1: fetch has a word on `data_input`.
- `data_input` input 32: instruction word.
- `pc_input` input 32: address of `data_input`.
- `stall_output` output 1: registered backpressure to fetch (fetch's `stall_input`).
- `branch_input` input 1: flush from execute; discards all held and incoming words.
- `stall_input` input 1: backpressure from execute.
- `valid_output` output 1: decoded bundle valid.
- `pc_output` output 32: pc of the decoded word.
- `instr_class` output 4: class enum (package).
- `rd`, `rs1`, `rs2` output 5 each: register indices.
- `funct3` output 3, `funct7` output 7: raw fields.
- `imm` output 32: sign-extended immediate; 0 for R-type.
- `illegal` output 1: word is not a legal encoding.

## Operation
- Upstream transfer: `valid_input && !stall_output`. Downstream transfer: `valid_output && !stall_input`.
- Storage: main register (drives outputs) and skid register, each with a valid bit. Decode runs combinationally on `data_input`; registers hold decoded bundles.
- Accept when main is empty or draining: the bundle goes to main. Accept when main is held (valid and `stall_input`): the bundle goes to skid. When main drains with skid valid, skid moves to main.
- `stall_output` equals skid valid, registered.
- Classes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, FENCE, SYSTEM, ILLEGAL.
- Immediates follow the I/S/B/U/J formats, sign-extended from bit 31. B and J have bit 0 = 0. U is `{word[31:12],12'b0}`.
- `illegal` is set, with class ILLEGAL, on any of:
  - `word[1:0] != 2'b11`
  - unknown opcode
  - BRANCH funct3 010/011
  - LOAD funct3 011/110/111
  - STORE funct3 > 010
  - JALR funct3 != 0
  - OP funct7 not 0000000, or 0100000 with funct3 other than 000/101
  - OP_IMM shift with a bad funct7
- A flagged word is still passed downstream.
- Flush (`branch_input`) clears both valid bits in the same cycle and drops the incoming word. Flush has priority over all other events.

## Timing
- Reset: all valid bits 0, `stall_output` 0, every data output 0, `instr_class` ILLEGAL encoding 0.
- Latency: accept in cycle N gives `valid_output` in N+1.
- Throughput: one per cycle while `stall_input` is low.
- `stall_input` rising with upstream streaming:
  - one more word is accepted into skid;
  - `stall_output` rises the following cycle;
  - no word is lost or duplicated.
- Simultaneous drain and accept with skid empty: main reloads, and the bubble-free path holds.
- Outputs stay stable while `valid_output && stall_input`.
- Reset asserted mid-stream clears asynchronously. The first accept is allowed on the first clock edge after release.

## Configuration
- `DECODE_RV32M_EN` defined: OP with funct7 0000001 (any funct3) is legal, class OP.
- Not defined: that encoding is illegal.

## Structure
- Package `kakacpu_pkg` holds:
  - opcode localparams;
  - `instr_class_t` enum;
  - `decoded_t` struct (pc, class, rd, rs1, rs2, funct3, funct7, imm, illegal).
- One sub-module `immediate_generator`: combinational, takes the word, produces the 32-bit imm per format.

## Test plan
- `0x00500093` (addi x1,x0,5) → class OP_IMM, rd=1, rs1=0, imm=0x00000005, `valid_output` one cycle after accept.
- `0xFE000EE3` (beq x0,x0,-4) → class BRANCH, imm=0xFFFFFFFC, illegal=0.
- `0x00000000` → illegal=1, class ILLEGAL, still presented with valid.
- Stream 8 words, hold `stall_input` for 3 cycles mid-stream → `stall_output` high after skid fills; output order is the 8 words, each once.
- Skid full, then `branch_input` pulse → next cycle `valid_output`=0 and `stall_output`=0; the word offered during the flush is never output.
- `0x022081B3` (mul x3,x1,x2) → illegal=0, class OP with `DECODE_RV32M_EN`; illegal=1 without it.

Source files
------------

// File: rtl/kakacpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : kakacpu_pkg
//  Brief    : Shared opcode constants, instruction classes and the decoded
//             bundle carried between decode and execute.
//  Revision : 1.0 - initial release
// ============================================================================
package kakacpu_pkg;

  // RV32I major opcodes (word[6:0]), low two bits always 2'b11
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // ILLEGAL is encoding 0 so a reset bundle reads as "nothing legal"
  typedef enum logic [3:0] {
    CLS_ILLEGAL = 4'd0,
    CLS_LUI     = 4'd1,
    CLS_AUIPC   = 4'd2,
    CLS_JAL     = 4'd3,
    CLS_JALR    = 4'd4,
    CLS_BRANCH  = 4'd5,
    CLS_LOAD    = 4'd6,
    CLS_STORE   = 4'd7,
    CLS_OP_IMM  = 4'd8,
    CLS_OP      = 4'd9,
    CLS_FENCE   = 4'd10,
    CLS_SYSTEM  = 4'd11
  } instr_class_t;

  typedef struct packed {
    logic [31:0]  pc;
    instr_class_t iclass;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [31:0]  imm;
    logic         illegal;
  } decoded_t;

endpackage
`default_nettype wire

// File: rtl/instruction_decode_immediate_generator.sv
`default_nettype none
// ============================================================================
//  Module   : immediate_generator
//  Brief    : Combinational RV32I immediate extraction. The format is picked
//             from the opcode; opcodes without an immediate yield zero.
//  Revision : 1.0 - initial release
// ============================================================================
module immediate_generator
  import kakacpu_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] imm
);

  // Select I/S/B/U/J layout by opcode, sign-extending from word[31]
  always_comb begin
    imm = '0;
    case (word[6:0])
      OPC_LUI, OPC_AUIPC:
        imm = {word[31:12], 12'b0};
      OPC_JAL:
        imm = {{12{word[31]}}, word[19:12], word[20], word[30:21], 1'b0};
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_FENCE, OPC_SYSTEM:
        imm = {{20{word[31]}}, word[31:20]};
      OPC_BRANCH:
        imm = {{20{word[31]}}, word[7], word[30:25], word[11:8], 1'b0};
      OPC_STORE:
        imm = {{20{word[31]}}, word[31:25], word[11:7]};
      default:
        imm = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instruction_decode.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_decode
//  Brief    : kakacpu decode stage. Decodes RV32I words combinationally and
//             buffers the bundles in a main + skid register pair so that the
//             backpressure to fetch is a plain flop.
//  Config   : DECODE_RV32M_EN - when defined, OP with funct7 0000001 is legal.
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_decode
  import kakacpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_input,
  input  logic [XLEN-1:0] data_input,
  input  logic [XLEN-1:0] pc_input,
  output logic            stall_output,
  input  logic            branch_input,
  input  logic            stall_input,
  output logic            valid_output,
  output logic [XLEN-1:0] pc_output,
  output logic [3:0]      instr_class,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [6:0]   opcode;
  logic [2:0]   f3;
  logic [6:0]   f7;
  logic [31:0]  dec_imm;
  instr_class_t cls;
  logic         legal;
  decoded_t     dec;

  decoded_t     main_q;
  decoded_t     skid_q;
  logic         main_valid;
  logic         skid_valid;
  logic         accept;

  assign opcode = data_input[6:0];
  assign f3     = data_input[14:12];
  assign f7     = data_input[31:25];

  immediate_generator u_imm (
    .word (data_input),
    .imm  (dec_imm)
  );

  // Classify the incoming word and check the encoding constraints per opcode
  always_comb begin
    cls   = CLS_ILLEGAL;
    legal = 1'b0;
    case (opcode)
      OPC_LUI:    begin cls = CLS_LUI;    legal = 1'b1; end
      OPC_AUIPC:  begin cls = CLS_AUIPC;  legal = 1'b1; end
      OPC_JAL:    begin cls = CLS_JAL;    legal = 1'b1; end
      OPC_JALR:   begin cls = CLS_JALR;   legal = (f3 == 3'b000); end
      OPC_BRANCH: begin cls = CLS_BRANCH; legal = (f3 != 3'b010) && (f3 != 3'b011); end
      OPC_LOAD:   begin cls = CLS_LOAD;   legal = (f3 != 3'b011) && (f3[2:1] != 2'b11); end
      OPC_STORE:  begin cls = CLS_STORE;  legal = (f3 <= 3'b010); end
      OPC_OP_IMM: begin
        cls = CLS_OP_IMM;
        // Only the shift forms constrain funct7 (it overlays imm[11:5])
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
      end
      OPC_OP: begin
        cls   = CLS_OP;
        legal = (f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
`ifdef DECODE_RV32M_EN
        if (f7 == 7'b0000001) legal = 1'b1;
`endif
      end
      OPC_FENCE:  begin cls = CLS_FENCE;  legal = 1'b1; end
      OPC_SYSTEM: begin cls = CLS_SYSTEM; legal = 1'b1; end
      default:    begin cls = CLS_ILLEGAL; legal = 1'b0; end
    endcase
    // Compressed/reserved quadrants are never legal here
    if (data_input[1:0] != 2'b11) legal = 1'b0;
  end

  // Assemble the bundle that will be captured on accept
  always_comb begin
    dec         = '0;
    dec.pc      = pc_input;
    dec.iclass  = legal ? cls : CLS_ILLEGAL;
    dec.rd      = data_input[11:7];
    dec.rs1     = data_input[19:15];
    dec.rs2     = data_input[24:20];
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.imm     = dec_imm;
    dec.illegal = !legal;
  end

  // Skid valid is itself a flop, so fetch never sees a path from execute
  assign stall_output = skid_valid;
  assign accept       = valid_input && !stall_output;

  // Main/skid buffer: flush wins, then drain-refill, then spill into skid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (branch_input) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || !stall_input) begin
      if (skid_valid) begin
        // Skid is only full while stall_output blocks new accepts
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign valid_output = main_valid;
  assign pc_output    = main_q.pc;
  assign instr_class  = main_q.iclass;
  assign rd           = main_q.rd;
  assign rs1          = main_q.rs1;
  assign rs2          = main_q.rs2;
  assign funct3       = main_q.funct3;
  assign funct7       = main_q.funct7;
  assign imm          = main_q.imm;
  assign illegal      = main_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_decode
//  Brief    : Directed bench for the decode stage: reset values, decode of
//             individual encodings, streaming under backpressure, flush and
//             asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_input;
  logic [31:0] data_input;
  logic [31:0] pc_input;
  logic        stall_output;
  logic        branch_input;
  logic        stall_input;
  logic        valid_output;
  logic [31:0] pc_output;
  logic [3:0]  instr_class;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  instruction_decode #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_input  (valid_input),
    .data_input   (data_input),
    .pc_input     (pc_input),
    .stall_output (stall_output),
    .branch_input (branch_input),
    .stall_input  (stall_input),
    .valid_output (valid_output),
    .pc_output    (pc_output),
    .instr_class  (instr_class),
    .rd           (rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .funct3       (funct3),
    .funct7       (funct7),
    .imm          (imm),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    valid_input = 1'b0; data_input = '0; pc_input = '0;
    branch_input = 1'b0; stall_input = 1'b0;
    step(); step();
    checks++; if (valid_output !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_output); end
    checks++; if (stall_output !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_output); end
    checks++; if (instr_class !== 4'd0) begin errors++; $display("FAIL reset_class got=%0d exp=0", instr_class); end
    checks++; if ({pc_output, imm, rd, rs1, rs2, funct3, funct7, illegal} !== '0) begin
      errors++; $display("FAIL reset_data pc=%h imm=%h rd=%0d illegal=%b exp=all zero", pc_output, imm, rd, illegal);
    end
    rst = 1'b1;
  endtask

  task automatic test_addi_latency();
    valid_input = 1'b1; data_input = 32'h00500093; pc_input = 32'h0000_0100;
    checks++; if (valid_output !== 1'b0) begin errors++; $display("FAIL addi_pre_valid got=%b exp=0", valid_output); end
    step();
    valid_input = 1'b0;
    checks++; if (valid_output !== 1'b1) begin errors++; $display("FAIL addi_valid got=%b exp=1", valid_output); end
    checks++; if (instr_class !== 4'd8 || illegal !== 1'b0) begin
      errors++; $display("FAIL addi_class got=%0d/%b exp=8/0", instr_class, illegal);
    end
    checks++; if (rd !== 5'd1 || rs1 !== 5'd0 || funct3 !== 3'd0) begin
      errors++; $display("FAIL addi_fields rd=%0d rs1=%0d f3=%0d exp=1/0/0", rd, rs1, funct3);
    end
    checks++; if (imm !== 32'h00000005) begin errors++; $display("FAIL addi_imm got=%h exp=00000005", imm); end
    checks++; if (pc_output !== 32'h00000100) begin errors++; $display("FAIL addi_pc got=%h exp=00000100", pc_output); end
    step();
    checks++; if (valid_output !== 1'b0) begin errors++; $display("FAIL addi_drain got=%b exp=0", valid_output); end
  endtask

  typedef struct {
    logic [31:0] word;
    logic [3:0]  cls;
    logic        ill;
    logic [31:0] imm;
  } vec_t;

  task automatic test_decode_table();
    vec_t v [15];
    v[0]  = '{32'hFE000EE3, 4'd5,  1'b0, 32'hFFFFFFFC}; // beq x0,x0,-4
    v[1]  = '{32'h00000000, 4'd0,  1'b1, 32'h00000000}; // all zero
    v[2]  = '{32'h12345037, 4'd1,  1'b0, 32'h12345000}; // lui
    v[3]  = '{32'hFFFFF117, 4'd2,  1'b0, 32'hFFFFF000}; // auipc
    v[4]  = '{32'h008000EF, 4'd3,  1'b0, 32'h00000008}; // jal x1,8
    v[5]  = '{32'hFE20AE23, 4'd7,  1'b0, 32'hFFFFFFFC}; // sw x2,-4(x1)
    v[6]  = '{32'h402081B3, 4'd9,  1'b0, 32'h00000000}; // sub
    v[7]  = '{32'h402091B3, 4'd0,  1'b1, 32'h00000000}; // 0100000 with sll
    v[8]  = '{32'h000010E7, 4'd0,  1'b1, 32'h00000000}; // jalr funct3=1
    v[9]  = '{32'h00003083, 4'd0,  1'b1, 32'h00000000}; // load funct3=011
    v[10] = '{32'h0020B023, 4'd0,  1'b1, 32'h00000000}; // store funct3=011
    v[11] = '{32'h4010D093, 4'd8,  1'b0, 32'h00000401}; // srai x1,x1,1
    v[12] = '{32'h40109093, 4'd0,  1'b1, 32'h00000401}; // slli bad funct7
    v[13] = '{32'h00500091, 4'd0,  1'b1, 32'h00000000}; // low bits 01
    v[14] = '{32'h0010200F, 4'd10, 1'b0, 32'h00000001}; // fence form
    for (int i = 0; i < 15; i++) begin
      valid_input = 1'b1; data_input = v[i].word; pc_input = 32'h2000 + 32'(i * 4);
      step();
      valid_input = 1'b0;
      checks++; if (valid_output !== 1'b1 || instr_class !== v[i].cls || illegal !== v[i].ill || imm !== v[i].imm) begin
        errors++;
        $display("FAIL decode_%h got v=%b cls=%0d ill=%b imm=%h exp v=1 cls=%0d ill=%b imm=%h",
                 v[i].word, valid_output, instr_class, illegal, imm, v[i].cls, v[i].ill, v[i].imm);
      end
    end
    step();
  endtask

  task automatic test_mul();
    logic exp_ill;
    logic [3:0] exp_cls;
`ifdef DECODE_RV32M_EN
    exp_ill = 1'b0; exp_cls = 4'd9;
`else
    exp_ill = 1'b1; exp_cls = 4'd0;
`endif
    valid_input = 1'b1; data_input = 32'h022081B3; pc_input = 32'h3000;
    step();
    valid_input = 1'b0;
    checks++; if (illegal !== exp_ill || instr_class !== exp_cls) begin
      errors++; $display("FAIL mul_class got=%0d/%b exp=%0d/%b", instr_class, illegal, exp_cls, exp_ill);
    end
    checks++; if (rd !== 5'd3 || rs1 !== 5'd1 || rs2 !== 5'd2 || funct7 !== 7'b0000001) begin
      errors++; $display("FAIL mul_fields rd=%0d rs1=%0d rs2=%0d f7=%b exp=3/1/2/0000001", rd, rs1, rs2, funct7);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [$];
    int idx = 0;
    logic will_accept;
    // Interval c lasts from edge c to edge c+1; execute stalls in 3..5
    for (int c = 0; c < 40; c++) begin
      stall_input = (c >= 3 && c <= 5);
      valid_input = (idx < 8);
      data_input  = 32'h00000013 | (32'(idx) << 20);
      pc_input    = 32'h1000 + 32'(idx * 4);
      if (c == 3) begin
        checks++; if (stall_output !== 1'b0) begin errors++; $display("FAIL stream_stall_c3 got=%b exp=0", stall_output); end
      end
      if (c == 4 || c == 5) begin
        checks++; if (stall_output !== 1'b1) begin errors++; $display("FAIL stream_stall_c%0d got=%b exp=1", c, stall_output); end
        checks++; if (valid_output !== 1'b1 || pc_output !== 32'h1008 || imm !== 32'd2) begin
          errors++; $display("FAIL stream_hold_c%0d got v=%b pc=%h imm=%h exp v=1 pc=00001008 imm=00000002", c, valid_output, pc_output, imm);
        end
      end
      if (c == 7) begin
        checks++; if (stall_output !== 1'b0) begin errors++; $display("FAIL stream_stall_c7 got=%b exp=0", stall_output); end
      end
      if (valid_output && !stall_input) got.push_back(pc_output);
      will_accept = valid_input && !stall_output;
      step();
      if (will_accept) idx++;
    end
    valid_input = 1'b0; stall_input = 1'b0;
    checks++; if (got.size() != 8) begin errors++; $display("FAIL stream_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got.size()) begin
        errors++; $display("FAIL stream_order_%0d got=missing exp=%h", i, 32'h1000 + 32'(i * 4));
      end else if (got[i] !== 32'h1000 + 32'(i * 4)) begin
        errors++; $display("FAIL stream_order_%0d got=%h exp=%h", i, got[i], 32'h1000 + 32'(i * 4));
      end
    end
  endtask

  task automatic test_flush();
    // Fill main then skid
    valid_input = 1'b1; data_input = 32'h00100013; pc_input = 32'h4000;
    step();
    stall_input = 1'b1; data_input = 32'h00200013; pc_input = 32'h4004;
    step();
    checks++; if (stall_output !== 1'b1 || valid_output !== 1'b1) begin
      errors++; $display("FAIL flush_prefill got stall=%b v=%b exp 1/1", stall_output, valid_output);
    end
    branch_input = 1'b1; data_input = 32'h00300013; pc_input = 32'h4008;
    step();
    branch_input = 1'b0; valid_input = 1'b0; stall_input = 1'b0;
    checks++; if (valid_output !== 1'b0 || stall_output !== 1'b0) begin
      errors++; $display("FAIL flush_clear got v=%b stall=%b exp 0/0", valid_output, stall_output);
    end
    // Flush with an otherwise-acceptable word: it must be dropped
    valid_input = 1'b1; branch_input = 1'b1; data_input = 32'h00400013; pc_input = 32'h400C;
    step();
    valid_input = 1'b0; branch_input = 1'b0;
    checks++; if (valid_output !== 1'b0) begin
      errors++; $display("FAIL flush_drop got v=%b pc=%h exp v=0", valid_output, pc_output);
    end
    step();
    checks++; if (valid_output !== 1'b0) begin
      errors++; $display("FAIL flush_quiet got v=%b pc=%h exp v=0", valid_output, pc_output);
    end
  endtask

  task automatic test_async_reset();
    valid_input = 1'b1; data_input = 32'h00500093; pc_input = 32'h5000;
    stall_input = 1'b1;
    step();
    step();
    checks++; if (valid_output !== 1'b1 || stall_output !== 1'b1) begin
      errors++; $display("FAIL areset_pre got v=%b stall=%b exp 1/1", valid_output, stall_output);
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (valid_output !== 1'b0 || stall_output !== 1'b0 || pc_output !== 32'h0) begin
      errors++; $display("FAIL areset_clear got v=%b stall=%b pc=%h exp 0/0/0", valid_output, stall_output, pc_output);
    end
    stall_input = 1'b0;
    step();
    rst = 1'b1; pc_input = 32'h5004;
    step();
    valid_input = 1'b0;
    checks++; if (valid_output !== 1'b1 || pc_output !== 32'h5004) begin
      errors++; $display("FAIL areset_first_accept got v=%b pc=%h exp 1/00005004", valid_output, pc_output);
    end
  endtask

  initial begin
    test_reset();
    test_addi_latency();
    test_decode_table();
    test_mul();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

endmodule
`default_nettype wire
